// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder: lane width, FSM encoding, flush length.
package systolic_feeder_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    // Cycles needed for the last skewed operand pair to reach the far corner cell.
    function automatic int flush_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_skew.sv
// Diagonal input skew: lane i is an i-stage shift register sharing one enable and sync clear.
module systolic_feeder_skew #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_clr,
    input  logic           i_en,
    input  logic [N*W-1:0] i_data,
    output logic [N*W-1:0] o_data
);

    for (genvar g = 0; g < N; g++) begin : g_lane
        if (g == 0) begin : g_direct
            assign o_data[W-1:0] = i_data[W-1:0];
        end else begin : g_shift
            logic [W-1:0] r_sr [g];

            always_ff @(posedge i_clk) begin
                if (i_reset || i_clr) begin
                    for (int s = 0; s < g; s++) r_sr[s] <= '0;
                end else if (i_en) begin
                    r_sr[0] <= i_data[g*W +: W];
                    for (int s = 1; s < g; s++) r_sr[s] <= r_sr[s-1];
                end
            end

            assign o_data[g*W +: W] = r_sr[g-1];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Tile sequencer for the NxN byte systolic array: clear, skewed feed, flush, result drain.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | waiting for start; streams not accepted
//  S_CLEAR | one-cycle array/skew clear, k_len already in the counter
//  S_FEED  | accept joint A/B beats until k_len beats taken
//  S_FLUSH | 2N-1 unconditional advances injecting zeros
//  S_DRAIN | shift N result words out of the array under res_ready
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int N  = 32,
    parameter int W  = LANE_W,
    parameter int KW = 16
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic [KW-1:0]  i_k_len,
    input  logic           i_a_valid,
    output logic           o_a_ready,
    input  logic [N*W-1:0] i_a_data,
    input  logic           i_b_valid,
    output logic           o_b_ready,
    input  logic [N*W-1:0] i_b_data,
    output logic           o_arr_reset,
    output logic           o_arr_input_valid,
    output logic           o_arr_mult_over,
    output logic [N*W-1:0] o_arr_in_row,
    output logic [N*W-1:0] o_arr_in_col,
    output logic [N*W-1:0] o_arr_in_data,
    input  logic [N*W-1:0] i_arr_out_data,
    output logic           o_res_valid,
    input  logic           i_res_ready,
    output logic [N*W-1:0] o_res_data,
    output logic           o_busy,
    output logic           o_done
);

    localparam int CW = (KW > 7) ? KW : 7;
    localparam logic [CW-1:0] FLUSH_CNT = CW'(flush_len(N));
    localparam logic [CW-1:0] DRAIN_CNT = CW'(N);

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_done, w_done_nxt;
    logic [N*W-1:0] r_res_hold;
    logic           w_adv, w_beat, w_feeding, w_draining;
    logic [N*W-1:0] w_skew_a_in, w_skew_b_in;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_res_hold <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            if (w_draining && i_res_ready) r_res_hold <= i_arr_out_data;
        end
    end

    // r_cnt is a down-counter reused per phase: beats left, flush cycles left, words left.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_beat      = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_cnt_nxt   = CW'(i_k_len);
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt   = FLUSH_CNT;
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                w_beat = i_a_valid && i_b_valid;
                w_adv  = w_beat;
                if (w_beat) begin
                    if (r_cnt == CW'(1)) begin
                        w_cnt_nxt   = FLUSH_CNT;
                        w_state_nxt = S_FLUSH;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
            end
            S_FLUSH: begin
                w_adv = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_cnt_nxt   = DRAIN_CNT;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_DRAIN: begin
                w_adv = i_res_ready;
                if (i_res_ready) begin
                    if (r_cnt == CW'(1)) begin
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_feeding   = (r_state == S_FEED);
    assign w_draining  = (r_state == S_DRAIN);
    assign w_skew_a_in = w_feeding ? i_a_data : '0;
    assign w_skew_b_in = w_feeding ? i_b_data : '0;

    systolic_feeder_skew #(.N(N), .W(W)) u_skew_a (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (r_state == S_CLEAR),
        .i_en    (w_adv),
        .i_data  (w_skew_a_in),
        .o_data  (o_arr_in_row)
    );

    systolic_feeder_skew #(.N(N), .W(W)) u_skew_b (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (r_state == S_CLEAR),
        .i_en    (w_adv),
        .i_data  (w_skew_b_in),
        .o_data  (o_arr_in_col)
    );

    assign o_a_ready         = w_beat;
    assign o_b_ready         = w_beat;
    assign o_arr_reset       = i_reset || (r_state == S_CLEAR);
    assign o_arr_input_valid = w_adv;
    assign o_arr_mult_over   = w_draining;
    assign o_arr_in_data     = '0;
    assign o_res_valid       = w_draining;
    assign o_res_data        = w_draining ? i_arr_out_data : r_res_hold;
    assign o_busy            = (r_state != S_IDLE);
    assign o_done            = r_done;

endmodule
